csc_row_gen: RTL and testbench

Row generator that sits directly downstream of the first-row nonzero builder in the matrix datapath. It accepts one first-row descriptor: up to four complex nonzeros plus their column indices. It then streams all `MAT_RANK` rows of the circulant sparse matrix, one row per cycle, under a valid/ready handshake. Row `r` reuses the first-row values; its column indices are the first-row indices cyclically shifted right by `r` (mod `MAT_RANK`).

---
 rtl/csc_row_gen_if.sv | 49 ++++
 rtl/csc_row_gen.sv | 108 ++++++++++
 tb/tb_csc_row_gen.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/csc_row_gen_if.sv
// Descriptor-in / row-out bundle for the circulant sparse row generator.
// The generator uses the slave view; the upstream builder and row consumer use the master view.
interface csc_row_gen_if #(
    parameter int unsigned MAT_RANK = 256
);
    localparam int unsigned INDEX_W = $clog2(MAT_RANK);

    logic [INDEX_W*4-1:0] Scol_index;
    logic signed [31:0]   S_val_i0, S_val_i1, S_val_i2, S_val_i3;
    logic signed [31:0]   S_val_r0, S_val_r1, S_val_r2, S_val_r3;
    logic                 S_vld_i;
    logic                 S_rdy_i;

    logic [INDEX_W-1:0]   row_idx;
    logic [INDEX_W*4-1:0] col_index;
    logic signed [31:0]   val_i0, val_i1, val_i2, val_i3;
    logic signed [31:0]   val_r0, val_r1, val_r2, val_r3;
    logic [3:0]           nz_mask;
    logic                 row_first;
    logic                 row_last;
    logic                 row_vld;
    logic                 row_rdy;

    modport slave (
        input  Scol_index,
        input  S_val_i0, S_val_i1, S_val_i2, S_val_i3,
        input  S_val_r0, S_val_r1, S_val_r2, S_val_r3,
        input  S_vld_i,
        output S_rdy_i,
        output row_idx, col_index,
        output val_i0, val_i1, val_i2, val_i3,
        output val_r0, val_r1, val_r2, val_r3,
        output nz_mask, row_first, row_last, row_vld,
        input  row_rdy
    );

    modport master (
        output Scol_index,
        output S_val_i0, S_val_i1, S_val_i2, S_val_i3,
        output S_val_r0, S_val_r1, S_val_r2, S_val_r3,
        output S_vld_i,
        input  S_rdy_i,
        input  row_idx, col_index,
        input  val_i0, val_i1, val_i2, val_i3,
        input  val_r0, val_r1, val_r2, val_r3,
        input  nz_mask, row_first, row_last, row_vld,
        output row_rdy
    );
endinterface

// File: rtl/csc_row_gen.sv
// Expands one first-row descriptor into all MAT_RANK rows of a circulant sparse matrix,
// one row per handshake; row r's column indices are the base indices shifted by r.
module csc_row_gen #(
    parameter int unsigned MAT_RANK = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    csc_row_gen_if.slave       bus
);
    localparam int unsigned INDEX_W = $clog2(MAT_RANK);
    localparam logic [INDEX_W-1:0] CNT_LAST = INDEX_W'(MAT_RANK - 1);

    typedef enum logic {IDLE, RUN} state_e;

    state_e                    state_q, state_d;
    logic [INDEX_W-1:0]        cnt_q, cnt_d;
    logic [3:0][INDEX_W-1:0]   base_q, base_d;
    logic [3:0][31:0]          vi_q, vi_d;
    logic [3:0][31:0]          vr_q, vr_d;
    logic [3:0]                mask_q, mask_d;

    logic                      row_vld_c;
    logic                      row_last_c;
    logic                      rdy_c;
    logic                      acc_c;
    logic                      rh_c;
    logic                      hi_zero_c;
    logic [3:0][INDEX_W-1:0]   col_c;

    assign row_vld_c  = (state_q == RUN);
    assign row_last_c = row_vld_c && (cnt_q == CNT_LAST);
    assign rdy_c      = (state_q == IDLE) || (row_last_c && bus.row_rdy);
    assign acc_c      = bus.S_vld_i && rdy_c;
    assign rh_c       = row_vld_c && bus.row_rdy;

    // Upper two slots collapse only when both index and value are zero (coincident position).
    assign hi_zero_c = (bus.Scol_index[2*INDEX_W +: INDEX_W] == '0)
                    && (bus.Scol_index[3*INDEX_W +: INDEX_W] == '0)
                    && (bus.S_val_i2 == '0) && (bus.S_val_r2 == '0)
                    && (bus.S_val_i3 == '0) && (bus.S_val_r3 == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        vi_d    = vi_q;
        vr_d    = vr_q;
        mask_d  = mask_q;
        if (acc_c) begin
            state_d = RUN;
            cnt_d   = '0;
            base_d  = bus.Scol_index;
            vi_d    = {bus.S_val_i3, bus.S_val_i2, bus.S_val_i1, bus.S_val_i0};
            vr_d    = {bus.S_val_r3, bus.S_val_r2, bus.S_val_r1, bus.S_val_r0};
            mask_d  = {~hi_zero_c, ~hi_zero_c, 2'b11};
        end else if (rh_c) begin
            if (cnt_q != CNT_LAST) begin
                cnt_d = cnt_q + INDEX_W'(1);
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
            vi_q    <= '0;
            vr_q    <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            vi_q    <= vi_d;
            vr_q    <= vr_d;
            mask_q  <= mask_d;
        end
    end

    // Modular add wraps naturally at INDEX_W bits because MAT_RANK is a power of two.
    always_comb begin
        col_c = '0;
        for (int k = 0; k < 4; k++) begin
            if (mask_q[k]) begin
                col_c[k] = base_q[k] + cnt_q;
            end
        end
    end

    assign bus.S_rdy_i   = rdy_c;
    assign bus.row_vld   = row_vld_c;
    assign bus.row_first = row_vld_c && (cnt_q == '0);
    assign bus.row_last  = row_last_c;
    assign bus.row_idx   = cnt_q;
    assign bus.col_index = col_c;
    assign bus.nz_mask   = mask_q;
    assign bus.val_i0    = vi_q[0];
    assign bus.val_i1    = vi_q[1];
    assign bus.val_i2    = vi_q[2];
    assign bus.val_i3    = vi_q[3];
    assign bus.val_r0    = vr_q[0];
    assign bus.val_r1    = vr_q[1];
    assign bus.val_r2    = vr_q[2];
    assign bus.val_r3    = vr_q[3];
endmodule

// File: tb/tb_csc_row_gen.sv
// Bench for csc_row_gen at MAT_RANK=8: queue-of-rows reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_csc_row_gen;
    localparam int unsigned MAT_RANK = 8;
    localparam int unsigned IW       = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    csc_row_gen_if #(.MAT_RANK(MAT_RANK)) bus ();

    csc_row_gen #(.MAT_RANK(MAT_RANK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        int               idx;
        logic [IW*4-1:0]  cols;
        logic [127:0]     vi;
        logic [127:0]     vr;
        logic [3:0]       mask;
    } row_t;

    row_t q[$];
    bit   after_reset = 1'b0;
    bit   chk_en      = 1'b0;
    int   checks      = 0;
    int   errors      = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [127:0] dut_vi();
        return {bus.val_i3, bus.val_i2, bus.val_i1, bus.val_i0};
    endfunction
    function automatic logic [127:0] dut_vr();
        return {bus.val_r3, bus.val_r2, bus.val_r1, bus.val_r0};
    endfunction

    // Model: an accepted descriptor becomes MAT_RANK queued rows; each handshake pops one.
    function automatic void push_desc();
        logic [127:0] vi, vr;
        logic [3:0]   m;
        int           b;
        row_t         e;
        vi = {bus.S_val_i3, bus.S_val_i2, bus.S_val_i1, bus.S_val_i0};
        vr = {bus.S_val_r3, bus.S_val_r2, bus.S_val_r1, bus.S_val_r0};
        m  = 4'b1111;
        if (bus.Scol_index[2*IW +: IW] == 0 && bus.Scol_index[3*IW +: IW] == 0 &&
            vi[127:64] == 0 && vr[127:64] == 0) m = 4'b0011;
        for (int r = 0; r < int'(MAT_RANK); r++) begin
            e.idx  = r;
            e.mask = m;
            e.cols = '0;
            e.vi   = '0;
            e.vr   = '0;
            for (int k = 0; k < 4; k++) begin
                if (m[k]) begin
                    b = int'(bus.Scol_index[k*IW +: IW]);
                    e.cols[k*IW +: IW] = IW'((b + r) % int'(MAT_RANK));
                    e.vi[k*32 +: 32]   = vi[k*32 +: 32];
                    e.vr[k*32 +: 32]   = vr[k*32 +: 32];
                end
            end
            q.push_back(e);
        end
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            after_reset = 1'b1;
        end else begin
            bit m_rdy;
            m_rdy = (q.size() == 0) || (q.size() == 1 && bus.row_rdy);
            if (q.size() > 0 && bus.row_rdy) void'(q.pop_front());
            if (bus.S_vld_i && m_rdy) begin
                push_desc();
                after_reset = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            row_t e;
            bit   exp_rdy;
            exp_rdy = (q.size() == 0) || (q.size() == 1 && bus.row_rdy);
            chk("s_rdy", bus.S_rdy_i, exp_rdy);
            chk("row_vld", bus.row_vld, q.size() > 0);
            if (q.size() > 0) begin
                e = q[0];
                chk("row_idx", bus.row_idx, e.idx);
                chk("col_index", bus.col_index, e.cols);
                chk("val_i", dut_vi(), e.vi);
                chk("val_r", dut_vr(), e.vr);
                chk("nz_mask", bus.nz_mask, e.mask);
                chk("row_first", bus.row_first, e.idx == 0);
                chk("row_last", bus.row_last, e.idx == int'(MAT_RANK) - 1);
            end else begin
                chk("row_first_idle", bus.row_first, 1'b0);
                chk("row_last_idle", bus.row_last, 1'b0);
                if (after_reset) begin
                    chk("idle_zero", {bus.row_idx, bus.col_index, bus.nz_mask, dut_vi(), dut_vr()}, '0);
                end
            end
        end
    end

    // Per-row snapshots captured by the watch task, keyed by row number.
    int              hs_idx[$];
    logic [IW*4-1:0] rec_cols [MAT_RANK];
    logic [3:0]      rec_mask [MAT_RANK];
    logic [127:0]    rec_vi   [MAT_RANK];
    logic [127:0]    rec_vr   [MAT_RANK];
    logic            rec_last [MAT_RANK];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_desc(input logic [IW*4-1:0] cols, input logic [127:0] vi, input logic [127:0] vr);
        bus.Scol_index = cols;
        {bus.S_val_i3, bus.S_val_i2, bus.S_val_i1, bus.S_val_i0} = vi;
        {bus.S_val_r3, bus.S_val_r2, bus.S_val_r1, bus.S_val_r0} = vr;
    endtask

    task automatic send(input logic [IW*4-1:0] cols, input logic [127:0] vi, input logic [127:0] vr);
        set_desc(cols, vi, vr);
        bus.S_vld_i = 1'b1;
        tick();
        bus.S_vld_i = 1'b0;
    endtask

    task automatic watch(input int ncyc, input bit rnd, input int pulse_row);
        bit pulse_next;
        int r;
        hs_idx.delete();
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (bus.S_vld_i) begin
                chk("ignored_desc_rdy", bus.S_rdy_i, 1'b0);
                chk("ignored_desc_row", bus.row_idx, pulse_row);
            end
            pulse_next = 1'b0;
            if (bus.row_vld && bus.row_rdy) begin
                r = int'(bus.row_idx);
                hs_idx.push_back(r);
                rec_cols[r] = bus.col_index;
                rec_mask[r] = bus.nz_mask;
                rec_vi[r]   = dut_vi();
                rec_vr[r]   = dut_vr();
                rec_last[r] = bus.row_last;
                if (r == pulse_row - 1) pulse_next = 1'b1;
            end
            tick();
            bus.S_vld_i = pulse_next;
            if (rnd) bus.row_rdy = 1'($urandom_range(0, 1));
        end
        bus.S_vld_i = 1'b0;
        bus.row_rdy = 1'b1;
    endtask

    task automatic check_order(input string name);
        chk({name, "_count"}, hs_idx.size(), MAT_RANK);
        for (int i = 0; i < hs_idx.size(); i++) chk({name, "_order"}, hs_idx[i], i);
        chk({name, "_done"}, bus.row_vld, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int  nrdy;
        bit  got_acc;
        bit  done;
        bus.S_vld_i = 1'b0;
        bus.row_rdy = 1'b1;
        set_desc('0, '0, '0);
        repeat (2) tick();
        chk_en = 1'b1;
        rst_n  = 1'b1;
        @(negedge clk);
        chk("reset_vld", bus.row_vld, 1'b0);
        chk("reset_rdy", bus.S_rdy_i, 1'b1);
        chk("reset_data", {bus.row_idx, bus.col_index, bus.nz_mask, dut_vi(), dut_vr()}, '0);
        tick();

        // 1: basic stream, indices {1,3,5,7}
        send({3'd7, 3'd5, 3'd3, 3'd1},
             {32'd13, 32'd12, 32'd11, 32'd10}, {32'd23, 32'd22, 32'd21, 32'd20});
        watch(14, 1'b0, -1);
        check_order("basic");
        chk("basic_row2_cols", rec_cols[2], {3'd1, 3'd7, 3'd5, 3'd3});
        chk("basic_row7_cols", rec_cols[7], {3'd6, 3'd4, 3'd2, 3'd0});
        chk("basic_row7_last", rec_last[7], 1'b1);
        chk("basic_mask", rec_mask[4], 4'b1111);
        chk("basic_vals", {rec_vi[6], rec_vr[6]},
            {32'd13, 32'd12, 32'd11, 32'd10, 32'd23, 32'd22, 32'd21, 32'd20});

        // 2: degenerate descriptor, indices {2,6,0,0}
        send({3'd0, 3'd0, 3'd6, 3'd2},
             {32'd0, 32'd0, 32'd8, 32'd7}, {32'd0, 32'd0, 32'hFFFF_FFFE, 32'hFFFF_FFFF});
        watch(14, 1'b0, -1);
        check_order("degen");
        chk("degen_mask", rec_mask[0], 4'b0011);
        chk("degen_row5_cols", rec_cols[5], {3'd0, 3'd0, 3'd3, 3'd7});
        for (int r = 0; r < int'(MAT_RANK); r++)
            chk("degen_hi_vals", {rec_vi[r][127:64], rec_vr[r][127:64]}, '0);

        // 3: backpressure
        send({3'd4, 3'd0, 3'd6, 3'd5},
             {32'hDEAD_BEEF, 32'd5, 32'hFFFF_FF00, 32'd1}, {32'd9, 32'd0, 32'd77, 32'h8000_0000});
        bus.row_rdy = 1'b0;
        watch(120, 1'b1, -1);
        check_order("bp");
        chk("bp_row1_cols", rec_cols[1], {3'd5, 3'd1, 3'd7, 3'd6});

        // 4: back-to-back, second descriptor held through first stream
        send({3'd7, 3'd5, 3'd3, 3'd1}, {4{32'd1}}, {4{32'd2}});
        set_desc({3'd5, 3'd1, 3'd4, 3'd0},
                 {32'd103, 32'd102, 32'd101, 32'd100}, {32'd203, 32'd202, 32'd201, 32'd200});
        bus.S_vld_i = 1'b1;
        nrdy = 0; got_acc = 1'b0; done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (got_acc) begin
                chk("b2b_first", {bus.row_vld, bus.row_first}, 2'b11);
                chk("b2b_row0_cols", bus.col_index, {3'd5, 3'd1, 3'd4, 3'd0});
                done = 1'b1;
            end else if (bus.S_rdy_i) begin
                nrdy++;
                chk("b2b_rdy_row", bus.row_idx, 3'd7);
                got_acc = 1'b1;
            end
            tick();
            if (got_acc) bus.S_vld_i = 1'b0;
        end
        chk("b2b_rdy_count", nrdy, 1);
        chk("b2b_seen", done, 1'b1);
        repeat (10) tick();
        @(negedge clk);
        chk("b2b_done", bus.row_vld, 1'b0);
        tick();

        // 5: mid-stream reset at row 4
        send({3'd3, 3'd2, 3'd1, 3'd0}, {4{32'd5}}, {4{32'd6}});
        done = 1'b0;
        for (int i = 0; i < 12 && !done; i++) begin
            @(negedge clk);
            if (bus.row_vld && bus.row_idx == 3'd3) done = 1'b1;
            tick();
        end
        chk("rst_reach_row3", done, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_vld", bus.row_vld, 1'b0);
        chk("midrst_rdy", bus.S_rdy_i, 1'b1);
        chk("midrst_data", {bus.row_idx, bus.col_index, bus.nz_mask, dut_vi(), dut_vr()}, '0);
        tick();
        send({3'd1, 3'd1, 3'd2, 3'd6}, {4{32'd9}}, {4{32'd3}});
        watch(14, 1'b0, -1);
        check_order("restart");
        chk("restart_row3_cols", rec_cols[3], {3'd4, 3'd4, 3'd5, 3'd1});

        // 6: descriptor pulsed at row 3 is ignored
        send({3'd0, 3'd2, 3'd4, 3'd6}, {4{32'd4}}, {4{32'd8}});
        set_desc({3'd1, 3'd1, 3'd1, 3'd1}, {4{32'd99}}, {4{32'd99}});
        watch(16, 1'b0, 3);
        check_order("ignore");
        chk("ignore_row7_cols", rec_cols[7], {3'd7, 3'd1, 3'd3, 3'd5});
        chk("ignore_vals", rec_vi[5], {4{32'd4}});

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
